// File: rtl/simd_isa_pkg.sv
// simd_isa_pkg: SIMD instruction widths, opcodes, legality check and encoder FSM states.
package simd_isa_pkg;
  localparam int regSize = 16;
  localparam int N = 8 + regSize;
  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_JMPC = 4'b1001;
  localparam logic [3:0] OP_ST   = 4'b1100;
  localparam logic [3:0] OP_LD   = 4'b1101;
  localparam logic [3:0] OP_SPC  = 4'b1111;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} enc_state_t;
  // ALU opcodes occupy the whole lower half; the upper half is sparse
  function automatic logic is_legal_opcode(input logic [3:0] op);
    return ~op[3] | (op inside {OP_JMP, OP_JMPC, OP_ST, OP_LD, OP_SPC});
  endfunction
endpackage

// File: rtl/instr_fifo.sv
// instr_fifo: small power-of-two FIFO of encoded words with registered head and occupancy.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int N = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [N-1:0]             i_wdata,
  input  logic                     i_pop,
  output logic [N-1:0]             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [DEPTH-1:0][N-1:0] r_mem;
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0] r_cnt;
  logic w_push;
  logic w_pop;
  assign o_full = r_cnt == (AW+1)'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_count = r_cnt;
  assign o_head = r_mem[r_rd];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  // storage is cleared on reset so the head reads zero after an abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_wdata;
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs {opcode, reg, imm} into N-bit words and streams them to instruction memory.
// Optional illegal-opcode filtering is enabled by defining ENC_ILLEGAL_CHECK_EN.
module instr_encoder
  import simd_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_opcode,
  input  logic [3:0]          in_reg,
  input  logic [regSize-1:0]  in_imm,
  input  logic                in_last,
  output logic                mem_we,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [N-1:0]        mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err_illegal,
  output logic                err_wrap,
  output logic [ADDR_W:0]     word_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  enc_state_t r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0] r_wcnt;
  logic r_err_ill;
  logic r_err_wrap;
  logic w_acc;
  logic w_push;
  logic w_pop;
  logic w_legal;
  logic w_full;
  logic w_empty;
  logic [CW-1:0] w_level;
`ifdef ENC_ILLEGAL_CHECK_EN
  assign w_legal = is_legal_opcode(in_opcode);
`else
  assign w_legal = 1'b1;
`endif
  assign in_ready = (r_state == S_RUN) & ~w_full;
  assign w_acc = in_valid & in_ready;
  assign w_push = w_acc & w_legal;
  assign mem_we = ~w_empty;
  assign w_pop = mem_we & mem_ready;
  assign mem_addr = r_addr;
  assign busy = r_state != S_IDLE;
  assign done = r_state == S_DONE;
  assign err_illegal = r_err_ill;
  assign err_wrap = r_err_wrap;
  assign word_count = r_wcnt;
  instr_fifo #(.DEPTH(DEPTH), .N(N)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata ({in_opcode, in_reg, in_imm}),
    .i_pop   (w_pop),
    .o_head  (mem_wdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_level)
  );
  // DRAIN looks ahead at the final pop so done follows the last write by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_wcnt <= '0;
      r_err_ill <= 1'b0;
      r_err_wrap <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_addr <= base_addr;
          r_wcnt <= '0;
          r_err_ill <= 1'b0;
          r_err_wrap <= 1'b0;
        end
        S_RUN: if (w_acc & in_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_empty | (w_level == CW'(1) & w_pop)) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
      if (w_pop) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_wcnt <= r_wcnt + (ADDR_W+1)'(1);
        if (&r_addr) r_err_wrap <= 1'b1;
      end
      if (w_acc & ~w_legal) r_err_ill <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized self-checking bench with a queue-based reference model of the encoder.
module tb_instr_encoder;
  localparam int DEPTH = 4;
`ifdef ENC_ILLEGAL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  typedef struct packed {logic [7:0] a; logic [23:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [7:0] base_addr = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic [3:0] in_opcode = '0;
  logic [3:0] in_reg = '0;
  logic [15:0] in_imm = '0;
  logic stall = 1'b0;
  logic rnd = 1'b0;
  logic rbit = 1'b1;
  logic mem_ready;
  logic in_ready, mem_we, busy, done, err_illegal, err_wrap;
  logic [7:0] mem_addr;
  logic [23:0] mem_wdata;
  logic [8:0] word_count;
  wr_t q[$];
  wr_t log_q[$];
  bit active, run, drain, exp_done, wrap, ill;
  logic [7:0] naddr;
  int wcount, acc_cnt, done_cnt;
  int checks = 0;
  int errors = 0;

  assign mem_ready = ~stall & (~rnd | rbit);
  always #5 clk = ~clk;
  always @(posedge clk) rbit <= 1'($urandom_range(0, 1));

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_reg(in_reg),
    .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err_illegal(err_illegal), .err_wrap(err_wrap), .word_count(word_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
    return !CHK_EN || !(op inside {4'hA, 4'hB, 4'hE});
  endfunction

  always @(negedge clk) begin : model
    wr_t w;
    bit was_active;
    bit last_acc;
    int sz;
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err_illegal", err_illegal, 0);
      chk("rst_err_wrap", err_wrap, 0);
      chk("rst_word_count", word_count, 0);
      q.delete();
      {active, run, drain, exp_done, wrap, ill} = '0;
      wcount = 0;
    end else begin
      sz = q.size();
      chk("busy", busy, active);
      chk("done", done, exp_done);
      chk("in_ready", in_ready, run && sz < DEPTH);
      chk("mem_we", mem_we, sz != 0);
      if (sz != 0) begin
        chk("mem_addr", mem_addr, q[0].a);
        chk("mem_wdata", mem_wdata, q[0].d);
      end
      chk("word_count", word_count, wcount);
      chk("err_wrap", err_wrap, wrap);
      chk("err_illegal", err_illegal, ill);
      was_active = active;
      last_acc = 1'b0;
      if (sz != 0 && mem_ready) begin
        w = q.pop_front();
        log_q.push_back(w);
        wcount++;
        if (w.a == 8'hFF) wrap = 1'b1;
      end
      if (run && in_valid && sz < DEPTH) begin
        acc_cnt++;
        if (legal(in_opcode)) begin
          q.push_back('{naddr, {in_opcode, in_reg, in_imm}});
          naddr++;
        end else ill = 1'b1;
        if (in_last) begin
          run = 1'b0;
          last_acc = 1'b1;
        end
      end
      if (exp_done) begin
        exp_done = 1'b0;
        active = 1'b0;
      end else if (drain && q.size() == 0) begin
        exp_done = 1'b1;
        drain = 1'b0;
      end
      if (last_acc) drain = 1'b1;
      if (!was_active && start) begin
        active = 1'b1;
        run = 1'b1;
        naddr = base_addr;
        wcount = 0;
        wrap = 1'b0;
        ill = 1'b0;
        acc_cnt = 0;
      end
    end
    if (done) done_cnt++;
  end

  task automatic start_sess(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [3:0] op, input logic [3:0] rg, input logic [15:0] im, input bit last);
    int n = 0;
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_opcode = op;
    in_reg = rg;
    in_imm = im;
    in_last = last;
    while (!ok && n < 500) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic chk_wr(input string nm, input int idx, input logic [7:0] a, input logic [23:0] d);
    if (idx < log_q.size()) begin
      chk({nm, "_addr"}, log_q[idx].a, a);
      chk({nm, "_data"}, log_q[idx].d, d);
    end else chk({nm, "_missing"}, log_q.size(), idx + 1);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    log_q.delete();
    done_cnt = 0;
    start_sess(8'h10);
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
    send(4'b0001, 4'b0101, 16'h00AA, 0);
    send(4'b1101, 4'b0000, 16'h0004, 0);
    send(4'b1000, 4'b0000, 16'h0020, 1);
    wait_idle();
    chk("basic_writes", log_q.size(), 3);
    chk_wr("basic0", 0, 8'h10, 24'h1500AA);
    chk_wr("basic1", 1, 8'h11, 24'hD00004);
    chk_wr("basic2", 2, 8'h12, 24'h800020);
    chk("basic_word_count", word_count, 3);
    chk("basic_done_pulses", done_cnt, 1);

    log_q.delete();
    stall = 1'b1;
    start_sess(8'h50);
    fork
      begin
        for (int i = 0; i < 6; i++) send(4'(i), 4'(i + 1), 16'(i * 3 + 7), i == 5);
      end
      begin
        repeat (8) @(negedge clk);
        chk("bp_accepted", acc_cnt, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_no_write", log_q.size(), 0);
        stall = 1'b0;
      end
    join
    wait_idle();
    chk("bp_writes", log_q.size(), 6);
    chk_wr("bp5", 5, 8'h55, 24'h560016);

    log_q.delete();
    start_sess(8'h20);
    send(4'h1, 4'h1, 16'h0001, 0);
    send(4'hE, 4'h2, 16'h1234, 0);
    send(4'h3, 4'h3, 16'h0003, 1);
    wait_idle();
    chk("ill_writes", log_q.size(), CHK_EN ? 2 : 3);
    chk("ill_flag", err_illegal, CHK_EN);
    chk_wr("ill1", 1, 8'h21, CHK_EN ? 24'h330003 : 24'hE21234);

    log_q.delete();
    start_sess(8'hFE);
    send(4'h2, 4'h0, 16'h0001, 0);
    send(4'h4, 4'h1, 16'h0002, 0);
    send(4'hF, 4'h2, 16'h0003, 1);
    wait_idle();
    chk_wr("wrap0", 0, 8'hFE, 24'h200001);
    chk_wr("wrap1", 1, 8'hFF, 24'h410002);
    chk_wr("wrap2", 2, 8'h00, 24'hF20003);
    chk("wrap_flag", err_wrap, 1);
    chk("wrap_word_count", word_count, 3);

    log_q.delete();
    stall = 1'b1;
    start_sess(8'h30);
    send(4'h5, 4'h5, 16'h5555, 0);
    send(4'h6, 4'h6, 16'h6666, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_busy", busy, 0);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_write", mem_we, 0);
    chk("abort_log", log_q.size(), 0);

    log_q.delete();
    start_sess(8'h40);
    send(4'h2, 4'h4, 16'h1111, 0);
    start = 1'b1;
    base_addr = 8'h80;
    @(posedge clk); #1;
    start = 1'b0;
    send(4'hC, 4'h5, 16'h2222, 0);
    send(4'h9, 4'h6, 16'h3333, 1);
    wait_idle();
    chk("restart_writes", log_q.size(), 3);
    chk_wr("restart2", 2, 8'h42, 24'h963333);

    rnd = 1'b1;
    for (int s = 0; s < 25; s++) begin
      start_sess((s % 5 == 0) ? 8'hFC : 8'($urandom));
      n = $urandom_range(1, 9);
      for (int k = 0; k < n; k++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send(4'($urandom), 4'($urandom), 16'($urandom), k == n - 1);
      end
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
